// File: rtl/tt_capture_pkg.sv
// Shared types and constants for the truth-table capture harness.
package tt_capture_pkg;

    localparam int unsigned N_IN = 4;
    localparam int unsigned TT_W = 16;

    typedef enum logic [1:0] {
        StIdle,
        StSweep,
        StHold
    } tt_state_e;

    // Truth table of the current reference netlist.
    localparam logic [TT_W-1:0] TT_16AD = 16'h16AD;

    function automatic logic [4:0] popcount16(input logic [TT_W-1:0] v);
        logic [4:0] acc;
        acc = '0;
        for (int i = 0; i < int'(TT_W); i++) begin
            acc = acc + {4'b0, v[i]};
        end
        return acc;
    endfunction

endpackage

// File: rtl/tt_capture_seq.sv
// Minterm and settle counters: walks x through 0..15, holding each value for
// SETTLE+1 cycles and flagging the cycle on which y should be sampled.
module tt_capture_seq
    import tt_capture_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            run_i,
    output logic [N_IN-1:0] x_o,
    output logic            sample_en_o,
    output logic            last_o
);

    localparam logic [3:0] SettleVal = 4'(SETTLE);

    logic [N_IN-1:0] x_q, x_d;
    logic [3:0]      cnt_q, cnt_d;

    // Sample strobe and next-state for the minterm/settle counters.
    always_comb begin
        x_d         = x_q;
        cnt_d       = cnt_q;
        sample_en_o = run_i && (cnt_q == 4'd0);
        last_o      = sample_en_o && (x_q == '1);
        if (load_i) begin
            x_d   = '0;
            cnt_d = SettleVal;
        end else if (run_i) begin
            if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                // After the last minterm x parks at 0 for the idle period.
                x_d   = (x_q == '1) ? '0 : x_q + 1'b1;
                cnt_d = SettleVal;
            end
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            cnt_q <= '0;
        end else begin
            x_q   <= x_d;
            cnt_q <= cnt_d;
        end
    end

    assign x_o = x_q;

endmodule

// File: rtl/tt_capture_unit.sv
// Sweeps a 4-input combinational block through all minterms, assembles its
// truth table, compares against a reference and offers the result on a
// valid/ready interface.
module tt_capture_unit
    import tt_capture_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [TT_W-1:0] expected,
    output logic [N_IN-1:0] x,
    input  logic            y_in,
    output logic            busy,
    output logic            tt_valid,
    input  logic            tt_ready,
    output logic [TT_W-1:0] tt_data,
    output logic            match,
    output logic [3:0]      first_mismatch,
    output logic [4:0]      ones
);

    tt_state_e       state_q, state_d;
    logic [TT_W-1:0] exp_q, exp_d;
    logic [TT_W-1:0] tt_q, tt_d;
    logic [TT_W-1:0] tt_data_q, tt_data_d;
    logic            match_q, match_d;
    logic [3:0]      fm_q, fm_d;
    logic [4:0]      ones_q, ones_d;

    logic            accept;
    logic            run;
    logic            sample_en;
    logic            last;
    logic [TT_W-1:0] tt_full;
    logic [TT_W-1:0] diff;
    logic [3:0]      fm_comb;

    assign accept = (state_q == StIdle) && start;
    assign run    = (state_q == StSweep);

    tt_capture_seq #(
        .SETTLE(SETTLE)
    ) u_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .run_i      (run),
        .x_o        (x),
        .sample_en_o(sample_en),
        .last_o     (last)
    );

    // Table shifts in from the top, so after 16 samples bit i holds y at x == i.
    assign tt_full = {y_in, tt_q[TT_W-1:1]};
    assign diff    = tt_full ^ exp_q;

    // Lowest differing bit index; 0 when the tables agree.
    always_comb begin
        fm_comb = '0;
        for (int i = int'(TT_W) - 1; i >= 0; i--) begin
            if (diff[i]) begin
                fm_comb = 4'(i);
            end
        end
    end

    // FSM next state plus table and result register updates.
    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        tt_d      = tt_q;
        tt_data_d = tt_data_q;
        match_d   = match_q;
        fm_d      = fm_q;
        ones_d    = ones_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StSweep;
                    exp_d     = expected;
                    tt_d      = '0;
                    tt_data_d = '0;
                    match_d   = 1'b0;
                    fm_d      = '0;
                    ones_d    = '0;
                end
            end
            StSweep: begin
                if (sample_en) begin
                    tt_d = tt_full;
                end
                if (last) begin
                    state_d   = StHold;
                    tt_data_d = tt_full;
                    match_d   = (diff == '0);
                    fm_d      = fm_comb;
                    ones_d    = popcount16(tt_full);
                end
            end
            StHold: begin
                if (tt_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            exp_q     <= '0;
            tt_q      <= '0;
            tt_data_q <= '0;
            match_q   <= 1'b0;
            fm_q      <= '0;
            ones_q    <= '0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            tt_q      <= tt_d;
            tt_data_q <= tt_data_d;
            match_q   <= match_d;
            fm_q      <= fm_d;
            ones_q    <= ones_d;
        end
    end

    assign busy           = (state_q != StIdle);
    assign tt_valid       = (state_q == StHold);
    assign tt_data        = tt_data_q;
    assign match          = match_q;
    assign first_mismatch = fm_q;
    assign ones           = ones_q;

endmodule

// File: tb/tb_tt_capture_unit.sv
// Directed bench: three instances cover SETTLE = 1, 3 and 0.
module tb_tt_capture_unit;
    import tt_capture_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // SETTLE=1 instance driven by the reference netlist truth table
    logic        start1 = 1'b0, ready1 = 1'b0, y1;
    logic [15:0] exp1 = '0, data1, ref_tt;
    logic [3:0]  x1, fm1;
    logic        busy1, valid1, match1;
    logic [4:0]  ones1;
    assign ref_tt = TT_16AD;
    assign y1     = ref_tt[x1];

    // SETTLE=3 instance with y tied high
    logic        start3 = 1'b0, ready3 = 1'b1;
    logic [15:0] exp3 = 16'hFFFF, data3;
    logic [3:0]  x3, fm3;
    logic        busy3, valid3, match3;
    logic [4:0]  ones3;

    // SETTLE=0 instance with y = x[0]
    logic        start0 = 1'b0, ready0 = 1'b1;
    logic [15:0] exp0 = 16'hAAAA, data0;
    logic [3:0]  x0, fm0;
    logic        busy0, valid0, match0;
    logic [4:0]  ones0;

    tt_capture_unit #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1), .x(x1), .y_in(y1),
        .busy(busy1), .tt_valid(valid1), .tt_ready(ready1), .tt_data(data1),
        .match(match1), .first_mismatch(fm1), .ones(ones1)
    );
    tt_capture_unit #(.SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .expected(exp3), .x(x3), .y_in(1'b1),
        .busy(busy3), .tt_valid(valid3), .tt_ready(ready3), .tt_data(data3),
        .match(match3), .first_mismatch(fm3), .ones(ones3)
    );
    tt_capture_unit #(.SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .expected(exp0), .x(x0), .y_in(x0[0]),
        .busy(busy0), .tt_valid(valid0), .tt_ready(ready0), .tt_data(data0),
        .match(match0), .first_mismatch(fm0), .ones(ones0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 ns after an edge; returns 1 ns after the accepting edge.
    task automatic pulse_start(input int sel);
        case (sel)
            0: start0 = 1'b1;
            1: start1 = 1'b1;
            default: start3 = 1'b1;
        endcase
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    // Edges counted from the accepting edge until tt_valid; bounded.
    task automatic wait_valid(input int sel, output int n);
        logic v;
        n = 0;
        v = 1'b0;
        while (!v && n < 300) begin
            tick();
            n++;
            case (sel)
                0: v = valid0;
                1: v = valid1;
                default: v = valid3;
            endcase
        end
    endtask

    initial begin
        int n;
        int bad;
        logic [15:0] held;

        // Reset state
        #2;
        check("rst_x", 32'(x1), 0);
        check("rst_busy", 32'(busy1), 0);
        check("rst_valid", 32'(valid1), 0);
        check("rst_data", 32'(data1), 0);
        check("rst_ones", 32'(ones1), 0);
        check("rst_fm", 32'(fm1), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reference function, matching expectation, SETTLE=1
        exp1   = 16'h16AD;
        ready1 = 1'b1;
        pulse_start(1);
        check("t1_busy", 32'(busy1), 1);
        wait_valid(1, n);
        check("t1_latency", 32'(n), 32);
        check("t1_data", 32'(data1), 32'h16AD);
        check("t1_match", 32'(match1), 1);
        check("t1_fm", 32'(fm1), 0);
        check("t1_ones", 32'(ones1), 8);
        check("t1_x_park", 32'(x1), 0);
        // start coincides with the handshake edge and must be dropped
        pulse_start(1);
        check("t1_idle_valid", 32'(valid1), 0);
        check("t1_idle_busy", 32'(busy1), 0);
        check("t1_data_kept", 32'(data1), 32'h16AD);
        tick();
        tick();
        check("t1_start_dropped", 32'(busy1), 0);

        // Mismatch at bit 0
        exp1 = 16'h16AC;
        pulse_start(1);
        wait_valid(1, n);
        check("t2_latency", 32'(n), 32);
        check("t2_match", 32'(match1), 0);
        check("t2_fm", 32'(fm1), 0);
        check("t2_ones", 32'(ones1), 8);
        tick();

        // Mismatch at bit 15
        exp1 = 16'h96AD;
        pulse_start(1);
        wait_valid(1, n);
        check("t3_match", 32'(match1), 0);
        check("t3_fm", 32'(fm1), 15);
        tick();

        // y tied high, SETTLE=3: x stepping and 64-cycle latency
        pulse_start(3);
        bad = 0;
        for (int j = 0; j < 64; j++) begin
            if (x3 !== 4'(j / 4) || valid3 !== 1'b0) bad++;
            tick();
        end
        check("t4_x_walk", 32'(bad), 0);
        check("t4_valid64", 32'(valid3), 1);
        check("t4_data", 32'(data3), 32'hFFFF);
        check("t4_ones", 32'(ones3), 16);
        check("t4_match", 32'(match3), 1);
        tick();

        // Backpressure with an ignored start in HOLD
        exp1   = 16'h16AD;
        ready1 = 1'b0;
        pulse_start(1);
        wait_valid(1, n);
        check("t5_latency", 32'(n), 32);
        bad = 0;
        for (int j = 0; j < 10; j++) begin
            start1 = (j == 4);
            exp1   = 16'h0000;
            if (valid1 !== 1'b1 || busy1 !== 1'b1 || data1 !== 16'h16AD ||
                match1 !== 1'b1 || ones1 !== 5'd8 || fm1 !== 4'd0) bad++;
            tick();
        end
        start1 = 1'b0;
        check("t5_hold_stable", 32'(bad), 0);
        ready1 = 1'b1;
        tick();
        check("t5_to_idle", 32'(busy1), 0);
        exp1 = 16'h16AD;
        pulse_start(1);
        wait_valid(1, n);
        check("t5_fresh_latency", 32'(n), 32);
        check("t5_fresh_match", 32'(match1), 1);
        tick();

        // Asynchronous reset mid-sweep
        pulse_start(1);
        repeat (17) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(busy1), 0);
        check("t6_rst_x", 32'(x1), 0);
        check("t6_rst_data", 32'(data1), 0);
        check("t6_rst_match", 32'(match1), 0);
        check("t6_rst_ones", 32'(ones1), 0);
        #1;
        rst_n = 1'b1;
        bad = 0;
        for (int j = 0; j < 40; j++) begin
            tick();
            if (valid1 !== 1'b0 || busy1 !== 1'b0) bad++;
        end
        check("t6_no_valid", 32'(bad), 0);
        pulse_start(1);
        wait_valid(1, n);
        check("t6_latency", 32'(n), 32);
        check("t6_data", 32'(data1), 32'h16AD);
        tick();

        // SETTLE=0 with y = x[0]
        pulse_start(0);
        wait_valid(0, n);
        check("t7_latency", 32'(n), 16);
        check("t7_data", 32'(data0), 32'hAAAA);
        check("t7_ones", 32'(ones0), 8);
        check("t7_match", 32'(match0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_capture_unit.md
Name: tt_capture_unit

Overview:
- Sequential harness stage that wraps a combinational 4-input single-output AIG function block.
- Upstream side: drives the function's inputs x0..x3 through all 16 minterms.
- Downstream side: samples y0 for each minterm, assembles the 16-bit truth table, compares it against an expected NPN-class value, and presents the result on a valid/ready interface.
- Used for in-system exact-synthesis checking of each generated netlist.

Parameters:
- SETTLE, 1, idle cycles after x changes before y_in is sampled (legal range 0..15).
- N_IN, 4, function input count; fixed at 4 in this revision. TT_W = 2**N_IN = 16.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse request to begin a sweep; honoured only in IDLE.
- expected  in  16  reference truth table; captured on accepted start.
- x  out  4  minterm driven to the function block; x[0] drives x0, x[3] drives x3. Registered.
- y_in  in  1  function output y0.
- busy  out  1  high in SWEEP and HOLD.
- tt_valid  out  1  result valid.
- tt_ready  in  1  consumer accepts result.
- tt_data  out  16  captured truth table; bit i = y0 at x == i.
- match  out  1  tt_data == captured expected.
- first_mismatch  out  4  lowest index i where tt_data[i] != expected[i]; 0 when match.
- ones  out  5  popcount of tt_data (0..16).

Behaviour:
- Reset (async, rst_n low): state IDLE, all outputs 0 (x=0, busy=0, tt_valid=0, tt_data=0, match=0, first_mismatch=0, ones=0). Internal counters and the expected register are cleared.
- States: IDLE, SWEEP, HOLD.
- IDLE -> SWEEP: start high at a rising edge.
  - expected is latched.
  - x <= 0.
  - Settle counter <= SETTLE.
  - The tt shift register is cleared.
  - busy <= 1.
- SWEEP: each minterm occupies exactly SETTLE+1 cycles.
  - The counter decrements while nonzero.
  - On the cycle the counter == 0, y_in is sampled into tt bit x.
  - If x == 15, go to HOLD; otherwise x <= x+1 and the counter reloads SETTLE.
  - x holds stable for the full SETTLE+1 window.
- Latency: tt_valid rises 16*(SETTLE+1) cycles after the edge that accepted start. With SETTLE=1 this is 32 cycles.
- Entering HOLD: tt_valid=1; tt_data, match, first_mismatch and ones are registered together in the same cycle.
  - x returns to 0.
  - The comparison and popcount may be computed combinationally from the assembled table and registered on entry.
- HOLD: all result outputs stay stable while tt_valid=1 and tt_ready=0.
  - On tt_valid & tt_ready: next state IDLE, tt_valid=0, busy=0.
  - tt_data, match, first_mismatch and ones keep their values until the next accepted start.
- start while busy (SWEEP or HOLD): ignored, with no queuing. start asserted in the same cycle as the HOLD handshake is also ignored; a new start is needed in IDLE.
- tt_ready while not tt_valid: no effect.
- rst_n asserted mid-sweep or in HOLD: immediate return to reset values; a partial table is never presented.
- SETTLE=0: one cycle per minterm, sampling in the same cycle x is presented. This is legal only because the function block is purely combinational.
- first_mismatch uses the lowest differing bit index.

Decomposition:
- Package tt_capture_pkg holds:
  - N_IN = 4 and TT_W = 16;
  - the state enum {IDLE, SWEEP, HOLD};
  - the constant TT_16AD = 16'h16AD, the truth table of the current reference netlist, for benches.
- Sub-module tt_capture_seq: minterm counter plus settle counter, emitting x, sample_en and last. The top holds the FSM, shift register, compare, priority encoder, popcount and handshake.

Test Plan:
- Drive y_in from the 16ad AIG model (y = n9 ^ n10), expected=16'h16AD, SETTLE=1, pulse start, tt_ready=1 → tt_valid at cycle 32, tt_data=16'h16AD, match=1, first_mismatch=0, ones=8.
- Same DUT, expected=16'h16AC → match=0, first_mismatch=0, ones=8. With expected=16'h96AD → first_mismatch=15.
- y_in tied 1, SETTLE=3 → tt_valid exactly 64 cycles after start, tt_data=16'hFFFF, ones=16. Check x stable for 4 cycles per minterm and stepping 0..15.
- Backpressure: tt_ready low for 10 cycles after tt_valid → outputs stable, busy=1. A start pulse during HOLD is ignored. After tt_ready, IDLE; a new start gives a fresh 32-cycle sweep.
- rst_n low at cycle 17 of a sweep → all outputs 0 asynchronously. After release, no tt_valid until a new start, then the correct 16'h16AD result.
- SETTLE=0, y_in = x[0] → tt_valid at cycle 16, tt_data=16'hAAAA, ones=8.
